// File: rtl/io_bus_parser_bank.sv
// rtl/io_bus_parser_bank.sv - bank of memory-mapped 8-bit IO registers behind one CPU data bus
// A single FSM tracks the active CPU transaction so each write commits once and each read clears once.
module io_bus_parser_bank #(
   parameter logic [15:0]             P_BASE_ADDR     = 16'hFF40,
   parameter int                      P_NUM_REGS      = 4,
   parameter logic [8*P_NUM_REGS-1:0] P_RST_VALS      = '0,
   parameter logic [8*P_NUM_REGS-1:0] P_WR_MASK       = '1,
   parameter logic [P_NUM_REGS-1:0]   P_CLEAR_ON_READ = '0,
   parameter logic [P_NUM_REGS-1:0]   P_WRITE_ONLY    = '0
) (
   input  logic                    I_CLK,
   input  logic                    I_RESET_L,
   inout  wire  [7:0]              IO_DATA_BUS,
   input  logic [15:0]             I_ADDR_BUS,
   input  logic                    I_WE_BUS_L,
   input  logic                    I_RE_BUS_L,
   input  logic [8*P_NUM_REGS-1:0] I_DATA_WR,
   input  logic [P_NUM_REGS-1:0]   I_REG_WR_EN,
   output logic [8*P_NUM_REGS-1:0] O_DATA_READ,
   output logic [P_NUM_REGS-1:0]   O_DBUS_WRITE,
   output logic [P_NUM_REGS-1:0]   O_DBUS_READ,
   output logic [P_NUM_REGS-1:0]   O_WAIT
);
   localparam int IW = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;

   typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         act_idx_q, act_idx_d;
   logic [7:0]            wr_shadow_q, wr_shadow_d;
   logic [7:0]            regs_q [P_NUM_REGS];
   logic [7:0]            regs_d [P_NUM_REGS];
   logic [15:0]           idx_full;
   logic [IW-1:0]         idx;
   logic                  hit, same_idx, commit, rd_done, bus_drive;
   logic [P_NUM_REGS-1:0] act_sel;

   assign idx_full = I_ADDR_BUS - P_BASE_ADDR;
   assign hit      = (I_ADDR_BUS >= P_BASE_ADDR) && (idx_full < 16'(P_NUM_REGS));
   assign idx      = idx_full[IW-1:0];
   assign same_idx = hit && (idx == act_idx_q);

   always_comb begin
      state_d     = state_q;
      act_idx_d   = act_idx_q;
      wr_shadow_d = wr_shadow_q;
      commit      = 1'b0;
      rd_done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit && !I_WE_BUS_L) begin
               state_d     = WR_ACT;
               act_idx_d   = idx;
               wr_shadow_d = IO_DATA_BUS;
            end else if (hit && !I_RE_BUS_L) begin
               state_d   = RD_ACT;
               act_idx_d = idx;
            end
         end
         WR_ACT: begin
            if (!I_WE_BUS_L && same_idx) begin
               wr_shadow_d = IO_DATA_BUS;
            end else begin
               state_d = IDLE;
               commit  = 1'b1;
            end
         end
         RD_ACT: begin
            if (I_RE_BUS_L || !same_idx) begin
               state_d = IDLE;
               rd_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lowest priority applied first so later assignments win per bit.
   always_comb begin
      for (int i = 0; i < P_NUM_REGS; i++) begin
         act_sel[i] = (act_idx_q == IW'(i));
         regs_d[i]  = regs_q[i];
         if (rd_done && act_sel[i] && P_CLEAR_ON_READ[i])
            regs_d[i] = P_RST_VALS[8*i +: 8];
         if (I_REG_WR_EN[i])
            regs_d[i] = I_DATA_WR[8*i +: 8];
         if (commit && act_sel[i])
            regs_d[i] = (wr_shadow_q & P_WR_MASK[8*i +: 8]) | (regs_d[i] & ~P_WR_MASK[8*i +: 8]);
         O_WAIT[i] = ((state_q == WR_ACT) && act_sel[i]) ||
                     (hit && !I_WE_BUS_L && (idx == IW'(i)));
         O_DATA_READ[8*i +: 8] = regs_q[i];
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         state_q      <= IDLE;
         act_idx_q    <= '0;
         wr_shadow_q  <= '0;
         O_DBUS_WRITE <= '0;
         O_DBUS_READ  <= '0;
         for (int i = 0; i < P_NUM_REGS; i++)
            regs_q[i] <= P_RST_VALS[8*i +: 8];
      end else begin
         state_q      <= state_d;
         act_idx_q    <= act_idx_d;
         wr_shadow_q  <= wr_shadow_d;
         O_DBUS_WRITE <= commit ? act_sel : '0;
         O_DBUS_READ  <= rd_done ? act_sel : '0;
         for (int i = 0; i < P_NUM_REGS; i++)
            regs_q[i] <= regs_d[i];
      end
   end

   assign bus_drive   = I_RESET_L && hit && !I_RE_BUS_L && I_WE_BUS_L && !P_WRITE_ONLY[idx];
   assign IO_DATA_BUS = bus_drive ? regs_q[idx] : 8'hzz;

endmodule

// File: tb/tb_io_bus_parser_bank.sv
// tb/tb_io_bus_parser_bank.sv - scoreboard bench for io_bus_parser_bank
module tb_io_bus_parser_bank;
   typedef struct packed {
      logic [3:0]  wr;
      logic [3:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, we_l, re_l, drv_en;
   logic [15:0] addr;
   logic [31:0] data_wr, data_rd, model;
   logic [3:0]  wr_en, pwr, prd, pwait;
   logic [7:0]  drv_val;
   tri1  [7:0]  bus;
   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;
   assign bus = drv_en ? drv_val : 8'hzz;

   io_bus_parser_bank #(
      .P_BASE_ADDR     (16'hFF40),
      .P_NUM_REGS      (4),
      .P_RST_VALS      (32'h0000_8500),
      .P_WR_MASK       (32'hFFFF_FFF8),
      .P_CLEAR_ON_READ (4'b0100),
      .P_WRITE_ONLY    (4'b1000)
   ) dut (
      .I_CLK        (clk),
      .I_RESET_L    (rst_n),
      .IO_DATA_BUS  (bus),
      .I_ADDR_BUS   (addr),
      .I_WE_BUS_L   (we_l),
      .I_RE_BUS_L   (re_l),
      .I_DATA_WR    (data_wr),
      .I_REG_WR_EN  (wr_en),
      .O_DATA_READ  (data_rd),
      .O_DBUS_WRITE (pwr),
      .O_DBUS_READ  (prd),
      .O_WAIT       (pwait)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe pulse must match the next queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (|pwr || |prd)) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pulse: got wr=%b rd=%b expected none", pwr, prd);
            end else begin
               e = exp_q.pop_front();
               check("pulse_wr", {28'h0, pwr}, {28'h0, e.wr});
               check("pulse_rd", {28'h0, prd}, {28'h0, e.rd});
               check("pulse_data", data_rd, e.data);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; we_l = 1'b1; re_l = 1'b0; addr = 16'hFF41;
      data_wr = '0; wr_en = '0; drv_en = 1'b0; drv_val = '0;
      model = 32'h0000_8500;
      tick(2);
      @(negedge clk);
      check("reset_regs", data_rd, 32'h0000_8500);
      check("reset_pulses", {24'h0, pwr, prd}, 32'h0);
      check("reset_bus_released", {24'h0, bus}, 32'h0000_00FF);
      re_l = 1'b1;
      tick();
      rst_n = 1'b1;
      tick(2);

      // CPU write 3C to FF41 held three cycles
      model[15:8] = 8'h3C;
      exp_q.push_back('{wr: 4'b0010, rd: 4'b0000, data: model});
      addr = 16'hFF41; drv_val = 8'h3C; drv_en = 1'b1; we_l = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("wait_during_write", {28'h0, pwait}, 32'h2);
         tick();
      end
      we_l = 1'b1; drv_en = 1'b0;
      @(negedge clk);
      check("no_commit_before_exit", data_rd, 32'h0000_8500);
      tick();
      @(negedge clk);
      check("write_commit", data_rd, 32'h0000_3C00);
      tick(2);

      // masked write with concurrent external write
      data_wr = 32'h0000_0005; wr_en = 4'b0001;
      tick();
      wr_en = '0;
      @(negedge clk);
      check("ext_write", data_rd, 32'h0000_3C05);
      model[7:0] = 8'hFA;
      exp_q.push_back('{wr: 4'b0001, rd: 4'b0000, data: model});
      addr = 16'hFF40; drv_val = 8'hFF; drv_en = 1'b1; we_l = 1'b0;
      data_wr = 32'h0000_0002; wr_en = 4'b0001;
      tick();
      wr_en = '0;
      tick();
      we_l = 1'b1; drv_en = 1'b0;
      tick(2);
      @(negedge clk);
      check("masked_write", data_rd, 32'h0000_3CFA);

      // clear-on-read of reg2
      data_wr = 32'h001F_0000; wr_en = 4'b0100;
      tick();
      wr_en = '0;
      model[23:16] = 8'h00;
      exp_q.push_back('{wr: 4'b0000, rd: 4'b0100, data: model});
      addr = 16'hFF42; re_l = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("read_bus", {24'h0, bus}, 32'h0000_001F);
         tick();
      end
      re_l = 1'b1;
      @(negedge clk);
      check("no_clear_mid_read", data_rd, 32'h001F_3CFA);
      tick();
      @(negedge clk);
      check("clear_on_read", data_rd, 32'h0000_3CFA);
      tick(2);

      // external write on the clear edge survives
      data_wr = 32'h001F_0000; wr_en = 4'b0100;
      tick();
      wr_en = '0;
      model[23:16] = 8'h04;
      exp_q.push_back('{wr: 4'b0000, rd: 4'b0100, data: model});
      re_l = 1'b0;
      tick(2);
      re_l = 1'b1; data_wr = 32'h0004_0000; wr_en = 4'b0100;
      tick();
      wr_en = '0;
      @(negedge clk);
      check("ext_beats_clear", data_rd, 32'h0004_3CFA);
      tick(2);

      // outside the bank and write-only register
      addr = 16'hFF44; re_l = 1'b0;
      @(negedge clk);
      check("oob_read_bus", {24'h0, bus}, 32'h0000_00FF);
      tick(2);
      re_l = 1'b1;
      tick(2);
      addr = 16'hFF3F; drv_val = 8'h55; drv_en = 1'b1; we_l = 1'b0;
      @(negedge clk);
      check("oob_wait", {28'h0, pwait}, 32'h0);
      tick(2);
      we_l = 1'b1; drv_en = 1'b0;
      tick(2);
      @(negedge clk);
      check("oob_no_change", data_rd, 32'h0004_3CFA);
      exp_q.push_back('{wr: 4'b0000, rd: 4'b1000, data: model});
      addr = 16'hFF43; re_l = 1'b0;
      @(negedge clk);
      check("write_only_bus", {24'h0, bus}, 32'h0000_00FF);
      tick(2);
      re_l = 1'b1;
      tick(3);

      // reset in the middle of a write, strobe still low afterwards
      model = 32'h0000_AA00;
      exp_q.push_back('{wr: 4'b0010, rd: 4'b0000, data: model});
      addr = 16'hFF41; drv_val = 8'hAA; drv_en = 1'b1; we_l = 1'b0;
      tick(2);
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_mid_write_regs", data_rd, 32'h0000_8500);
      check("reset_mid_write_pulses", {24'h0, pwr, prd}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick(2);
      we_l = 1'b1; drv_en = 1'b0;
      tick();
      @(negedge clk);
      check("write_after_reset", data_rd, 32'h0000_AA00);
      tick(2);

      // address switch with strobe held low commits both registers
      exp_q.push_back('{wr: 4'b0001, rd: 4'b0000, data: 32'h0000_AA10});
      exp_q.push_back('{wr: 4'b0010, rd: 4'b0000, data: 32'h0000_2210});
      addr = 16'hFF40; drv_val = 8'h11; drv_en = 1'b1; we_l = 1'b0;
      tick();
      addr = 16'hFF41; drv_val = 8'h22;
      @(negedge clk);
      check("wait_addr_switch", {28'h0, pwait}, 32'h3);
      tick(2);
      we_l = 1'b1; drv_en = 1'b0;
      tick(3);
      @(negedge clk);
      check("switch_final", data_rd, 32'h0000_2210);
      tick(3);

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/io_bus_parser_bank.md
Name: io_bus_parser_bank

Overview:
- Bank of P_NUM_REGS contiguous memory-mapped 8-bit IO registers behind one tristate CPU data bus port. Replaces per-register parser instances for peripherals with register groups such as LCD, sound and timer.
- Adds transaction tracking: single commit per CPU write, single-pulse write/read strobes, per-bit CPU write masks, and clear-on-read that fires once at the end of a read.
- Sits between the memory router IO bus and the peripheral cores.

Parameters:
- P_BASE_ADDR, 16'hFF40: address of register 0. Register i is at P_BASE_ADDR+i.
- P_NUM_REGS, 4: number of registers, 1..16.
- P_RST_VALS, {8*P_NUM_REGS{1'b0}}: reset and clear value. Byte i belongs to register i.
- P_WR_MASK, {8*P_NUM_REGS{1'b1}}: per-bit CPU-writable mask. A 0 bit is hardware-owned and read-only to the CPU.
- P_CLEAR_ON_READ, {P_NUM_REGS{1'b0}}: bit i set means register i returns to its P_RST_VALS byte after each CPU read transaction.
- P_WRITE_ONLY, {P_NUM_REGS{1'b0}}: bit i set means register i never drives the bus.

Ports:
- I_CLK  in  1  system clock; all state updates on the rising edge.
- I_RESET_L  in  1  reset, asynchronous, active-low.
- IO_DATA_BUS  inout  8  CPU data bus.
- I_ADDR_BUS  in  16  CPU address.
- I_WE_BUS_L  in  1  CPU write strobe, active-low.
- I_RE_BUS_L  in  1  CPU read strobe, active-low.
- I_DATA_WR  in  8*P_NUM_REGS  external write data. Byte i goes to register i.
- I_REG_WR_EN  in  P_NUM_REGS  external write enables.
- O_DATA_READ  out  8*P_NUM_REGS  current register contents.
- O_DBUS_WRITE  out  P_NUM_REGS  one-cycle pulse after a CPU write commits.
- O_DBUS_READ  out  P_NUM_REGS  one-cycle pulse after a CPU read transaction ends.
- O_WAIT  out  P_NUM_REGS  CPU write to register i in progress.

Behaviour:
- Decode:
  - idx = I_ADDR_BUS - P_BASE_ADDR.
  - hit = (I_ADDR_BUS >= P_BASE_ADDR) and (idx < P_NUM_REGS).
  - Addresses outside the bank are ignored entirely.
- FSM states: IDLE, WR_ACT, RD_ACT. The FSM also holds latched index act_idx and shadow byte wr_shadow.
- IDLE:
  - hit and WE_L=0 -> WR_ACT; latch act_idx and wr_shadow<=IO_DATA_BUS.
  - Otherwise hit and RE_L=0 -> RD_ACT; latch act_idx.
  - WE_L has priority if both strobes are low, and the bus is not driven in that case.
- WR_ACT:
  - While WE_L=0 and idx==act_idx, wr_shadow<=IO_DATA_BUS every cycle (the last bus value wins).
  - Exit when WE_L=1 or idx!=act_idx -> IDLE.
  - Commit on the exit edge: reg[act_idx] <= (wr_shadow & mask) | (reg & ~mask).
  - O_DBUS_WRITE[act_idx]=1 for exactly the following cycle.
  - Commit latency is 1 cycle after the last strobed cycle.
- RD_ACT:
  - Exit when RE_L=1 or idx!=act_idx -> IDLE.
  - On the exit edge, if P_CLEAR_ON_READ[act_idx], the register is loaded with its reset byte.
  - O_DBUS_READ[act_idx]=1 the next cycle.
  - The clear never occurs mid-read; the CPU sees a stable value throughout the read.
- Bus drive is combinational: IO_DATA_BUS = reg[idx] when hit & RE_L=0 & WE_L=1 & !P_WRITE_ONLY[idx], else 8'hZZ.
- O_WAIT[i] = (state==WR_ACT & act_idx==i) | (hit & WE_L=0 & idx==i). This is combinational.
- External writes (I_REG_WR_EN[i]) update register i every cycle, all bits, from I_DATA_WR byte i.
- Same-edge priority, per bit, highest first:
  1. CPU commit on CPU-writable bits.
  2. External write.
  3. Clear-on-read.
  4. Hold.
  - Hardware-owned bits are therefore never lost to a CPU write.
  - An external write coinciding with the clear edge survives.
- Back-to-back transactions: the exit edge returns to IDLE. A new strobe is sampled in IDLE the next cycle, so a min gap of 1 cycle between transactions is required.
- Address change while a strobe stays low ends the current transaction. The new address starts from IDLE.
- Async reset (I_RESET_L=0):
  - Registers take P_RST_VALS.
  - State=IDLE; act_idx=0; wr_shadow=0.
  - O_DBUS_WRITE=0; O_DBUS_READ=0.
  - Bus is released.
  - An in-flight write is discarded with no commit and no pulse.
  - After release, a still-low strobe starts a fresh transaction.

Test Plan:
- Reset with defaults, P_RST_VALS byte1=8'h85: O_DATA_READ byte1=8'h85, all pulses 0, bus Z; then CPU write 8'h3C to FF41 held 3 cycles -> reg1=8'h3C one cycle after WE_L rises, single O_DBUS_WRITE[1] pulse, O_WAIT[1] high all 3 cycles.
- P_WR_MASK byte0=8'hF8, reg0=8'h05; CPU writes 8'hFF to FF40 while I_REG_WR_EN[0] pulses 8'h02 -> reg0=8'hFA.
- P_CLEAR_ON_READ[2]=1, reg2=8'h1F; CPU read FF42 for 2 cycles -> bus shows 8'h1F both cycles; reg2=8'h00 after exit; one O_DBUS_READ[2] pulse. Repeat with external write 8'h04 on the exit edge -> reg2=8'h04.
- Read FF44 with P_NUM_REGS=4 and write FF3F -> bus Z, no register change, no pulses; P_WRITE_ONLY[3]=1 read FF43 -> bus Z.
- Assert I_RESET_L=0 mid-write to FF41 (8'hAA) -> reg1=reset byte, no O_DBUS_WRITE; WE_L still low after release -> commit of 8'hAA after strobe ends.
- Write FF40 then change address to FF41 with WE_L held low -> reg0 commits, then reg1 commits, two distinct pulses.
